// File: rtl/iddmm_ctrl_pkg.sv
// Shared types and default constants for the iddmm_cal sequencer.
package iddmm_pkg;

  localparam int unsigned IDDMM_N       = 16;
  localparam int unsigned IDDMM_GAP     = 4;
  localparam int unsigned IDDMM_TIMEOUT = 64;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOP,
    S_GAP,
    S_WAIT,
    S_FIN
  } iddmm_ctrl_state_t;

  // 16-bit increment that sticks at all-ones
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == '1) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/iddmm_ctrl_if.sv
// Control/status bundle between the sequencer, the iddmm_cal datapath and the
// modular-exponentiation top level. master = sequencer side.
interface iddmm_ctrl_if
  import iddmm_pkg::*;
#(
  parameter int unsigned N      = IDDMM_N,
  parameter int unsigned ADDR_W = $clog2(N)
);

  logic              start;
  logic              busy;
  logic              done;
  logic              result_sel;
  logic              error;
  logic [ADDR_W-1:0] i_cnt;
  logic [ADDR_W:0]   j_cnt;
  logic              loop_en;
  logic              cal_done;
  logic              cal_sign;
  logic [15:0]       run_cycles;

  modport master (
    input  start, cal_done, cal_sign,
    output busy, done, result_sel, error, i_cnt, j_cnt, loop_en, run_cycles
  );

  modport slave (
    output start, cal_done, cal_sign,
    input  busy, done, result_sel, error, i_cnt, j_cnt, loop_en, run_cycles
  );

endinterface

// File: rtl/iddmm_ctrl_cnt.sv
// Nested outer/inner limb counter: j runs 0..N, i runs 0..N-1.
// On the last inner step of the last outer pass, i holds and j returns to 0.
module iddmm_ctrl_cnt #(
  parameter int unsigned N      = 16,
  parameter int unsigned ADDR_W = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              step,
  output logic [ADDR_W-1:0] i_cnt,
  output logic [ADDR_W:0]   j_cnt,
  output logic              j_last,
  output logic              i_last
);

  assign j_last = (j_cnt == (ADDR_W+1)'(N));
  assign i_last = (i_cnt == ADDR_W'(N - 1));

  // Advance j each step; wrap into the next outer index at j=N
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      i_cnt <= '0;
      j_cnt <= '0;
    end else if (step) begin
      if (j_last) begin
        j_cnt <= '0;
        if (!i_last) i_cnt <= i_cnt + ADDR_W'(1);
      end else begin
        j_cnt <= j_cnt + (ADDR_W+1)'(1);
      end
    end
  end

endmodule

// File: rtl/iddmm_ctrl.sv
// Sequencer for the iddmm_cal Montgomery multiply datapath.
// Optional watchdog on the WAIT state: define IDDMM_CTRL_TIMEOUT_EN.
module iddmm_ctrl
  import iddmm_pkg::*;
#(
  parameter int unsigned N       = IDDMM_N,
  parameter int unsigned ADDR_W  = $clog2(N),
  parameter int unsigned GAP     = IDDMM_GAP,
  parameter int unsigned TIMEOUT = IDDMM_TIMEOUT
) (
  input  logic         clk,
  input  logic         rst,
  iddmm_ctrl_if.master bus
);

  iddmm_ctrl_state_t state_q, state_d;
  logic              j_last, i_last;
  logic              cnt_step, cnt_clr;
  logic [3:0]        gap_cnt;
  logic [15:0]       cyc_cnt;
  logic [15:0]       run_cycles_q;
  logic              result_sel_q;

  iddmm_ctrl_cnt #(.N(N), .ADDR_W(ADDR_W)) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (cnt_clr),
    .step   (cnt_step),
    .i_cnt  (bus.i_cnt),
    .j_cnt  (bus.j_cnt),
    .j_last (j_last),
    .i_last (i_last)
  );

`ifdef IDDMM_CTRL_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_cnt;
  logic            error_q;
  logic            wd_expired;

  assign wd_expired = (wd_cnt == '0);

  // Watchdog reloads outside WAIT, so it holds TIMEOUT on WAIT entry
  always_ff @(posedge clk) begin
    if (rst || state_q != S_WAIT) wd_cnt <= WD_W'(TIMEOUT);
    else if (!wd_expired)         wd_cnt <= wd_cnt - WD_W'(1);
  end

  // Sticky timeout flag
  always_ff @(posedge clk) begin
    if (rst) error_q <= 1'b0;
    else if (state_q == S_WAIT && !bus.cal_done && wd_expired) error_q <= 1'b1;
  end

  assign bus.error = error_q;
`else
  assign bus.error = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (bus.start) state_d = S_LOOP;
      S_LOOP: begin
        if (j_last) begin
          if (i_last)        state_d = S_WAIT;
          else if (GAP != 0) state_d = S_GAP;
        end
      end
      S_GAP:  if (gap_cnt == '0) state_d = S_LOOP;
      S_WAIT: begin
        if (bus.cal_done) state_d = S_FIN;
`ifdef IDDMM_CTRL_TIMEOUT_EN
        else if (wd_expired) state_d = S_FIN;
`endif
      end
      S_FIN:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Moore outputs decoded from the state register; counters clear in FIN
  // so IDLE always presents zeros
  always_comb begin
    bus.busy    = (state_q != S_IDLE);
    bus.done    = (state_q == S_FIN);
    bus.loop_en = (state_q == S_LOOP);
    cnt_step    = (state_q == S_LOOP);
    cnt_clr     = (state_q == S_FIN);
  end

  // Gap counter preloads GAP-1 during LOOP and counts down in GAP
  always_ff @(posedge clk) begin
    if (rst)                                  gap_cnt <= '0;
    else if (state_q == S_LOOP)               gap_cnt <= 4'(GAP - 1);
    else if (state_q == S_GAP && gap_cnt != '0) gap_cnt <= gap_cnt - 4'd1;
  end

  // Final-subtraction select latched from the datapath sign
  always_ff @(posedge clk) begin
    if (rst) begin
      result_sel_q <= 1'b0;
    end else if (state_q == S_WAIT) begin
      if (bus.cal_done) result_sel_q <= bus.cal_sign;
`ifdef IDDMM_CTRL_TIMEOUT_EN
      else if (wd_expired) result_sel_q <= 1'b0;
`endif
    end
  end

  // cyc_cnt includes the current cycle; preset to 1 in IDLE so the first
  // LOOP cycle reads 1, and the FIN cycle is added when publishing
  always_ff @(posedge clk) begin
    if (rst)                    cyc_cnt <= '0;
    else if (state_q == S_IDLE) cyc_cnt <= 16'd1;
    else                        cyc_cnt <= sat_inc16(cyc_cnt);
  end

  // Publish the run length so it is valid alongside done
  always_ff @(posedge clk) begin
    if (rst) run_cycles_q <= '0;
    else if (state_q == S_WAIT && state_d == S_FIN) run_cycles_q <= sat_inc16(cyc_cnt);
  end

  assign bus.result_sel = result_sel_q;
  assign bus.run_cycles = run_cycles_q;

endmodule

// File: tb/tb_iddmm_ctrl.sv
// Scoreboard bench for iddmm_ctrl: stimulus pushes expected loop/done events,
// a negedge monitor pops and compares them as the DUTs present outputs.
module tb_iddmm_ctrl;

  typedef struct packed { int cyc; int i; int j; } loop_exp_t;
  typedef struct packed { int cyc; int sel; int run; int err; } done_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  loop_exp_t lq[2][$];
  done_exp_t dq[2][$];

  iddmm_ctrl_if #(.N(4)) bus_a ();
  iddmm_ctrl_if #(.N(4)) bus_b ();

  iddmm_ctrl #(.N(4), .GAP(2), .TIMEOUT(8)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  iddmm_ctrl #(.N(4), .GAP(0), .TIMEOUT(8)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Expected loop_en cycles for one run started by start in cycle c
  task automatic push_run(input int id, input int c, input int gap, input int count, output int w);
    loop_exp_t e;
    int k;
    k = 0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j <= 4; j++) begin
        if (k < count) begin
          e.cyc = c + 1 + i * (5 + gap) + j;
          e.i = i;
          e.j = j;
          lq[id].push_back(e);
        end
        k++;
      end
    end
    w = c + 1 + 4 * 5 + 3 * gap;
  endtask

  task automatic push_done(input int id, input int c, input int sel, input int run, input int err);
    done_exp_t e;
    e.cyc = c; e.sel = sel; e.run = run; e.err = err;
    dq[id].push_back(e);
  endtask

  task automatic mon(input int id, input logic le, input logic [1:0] i, input logic [2:0] j,
                     input logic busy, input logic dn, input logic sel,
                     input logic [15:0] run, input logic err);
    loop_exp_t l;
    done_exp_t d;
    if (le === 1'b1) begin
      chk($sformatf("loop_en_expected[%0d]", id), lq[id].size() != 0, 1);
      if (lq[id].size() != 0) begin
        l = lq[id].pop_front();
        chk($sformatf("loop_cycle[%0d]", id), cyc, l.cyc);
        chk($sformatf("i_cnt[%0d]", id), i, l.i);
        chk($sformatf("j_cnt[%0d]", id), j, l.j);
        chk($sformatf("busy_in_loop[%0d]", id), busy, 1);
      end
    end else if (busy === 1'b1) begin
      chk($sformatf("j_cnt_not_loop[%0d]", id), j, 0);
    end
    if (dn === 1'b1) begin
      chk($sformatf("done_expected[%0d]", id), dq[id].size() != 0, 1);
      if (dq[id].size() != 0) begin
        d = dq[id].pop_front();
        chk($sformatf("done_cycle[%0d]", id), cyc, d.cyc);
        chk($sformatf("result_sel[%0d]", id), sel, d.sel);
        chk($sformatf("run_cycles[%0d]", id), run, d.run);
        chk($sformatf("error[%0d]", id), err, d.err);
      end
    end
  endtask

  // Monitor: compare whatever the DUTs present, away from the active edge
  always @(negedge clk) begin
    mon(0, bus_a.loop_en, bus_a.i_cnt, bus_a.j_cnt, bus_a.busy, bus_a.done,
        bus_a.result_sel, bus_a.run_cycles, bus_a.error);
    mon(1, bus_b.loop_en, bus_b.i_cnt, bus_b.j_cnt, bus_b.busy, bus_b.done,
        bus_b.result_sel, bus_b.run_cycles, bus_b.error);
  end

  task automatic chk_reset_a(input string tag);
    chk({tag, "_busy"}, bus_a.busy, 0);
    chk({tag, "_done"}, bus_a.done, 0);
    chk({tag, "_result_sel"}, bus_a.result_sel, 0);
    chk({tag, "_error"}, bus_a.error, 0);
    chk({tag, "_i_cnt"}, bus_a.i_cnt, 0);
    chk({tag, "_j_cnt"}, bus_a.j_cnt, 0);
    chk({tag, "_loop_en"}, bus_a.loop_en, 0);
    chk({tag, "_run_cycles"}, bus_a.run_cycles, 0);
  endtask

  initial begin
    int c, w, c2, w2;
    bus_a.start = 1'b0; bus_a.cal_done = 1'b0; bus_a.cal_sign = 1'b0;
    bus_b.start = 1'b0; bus_b.cal_done = 1'b0; bus_b.cal_sign = 1'b0;
    wait_cyc(3);
    rst = 1'b0;
    chk_reset_a("reset");
    chk("reset_b_busy", bus_b.busy, 0);

    // Run 1: GAP=2, spurious cal_done in LOOP, cal_done 5 cycles into WAIT
    wait_cyc(5);
    c = cyc;
    bus_a.start = 1'b1;
    push_run(0, c, 2, 20, w);
    wait_cyc(c + 1); bus_a.start = 1'b0;
    wait_cyc(c + 3); bus_a.cal_done = 1'b1; bus_a.cal_sign = 1'b0;
    wait_cyc(c + 4); bus_a.cal_done = 1'b0;
    wait_cyc(w + 5); bus_a.cal_done = 1'b1; bus_a.cal_sign = 1'b1;
    push_done(0, w + 6, 1, 33, 0);
    wait_cyc(w + 6); bus_a.cal_done = 1'b0; bus_a.cal_sign = 1'b0;
    wait_cyc(w + 8);
    chk("idle_busy", bus_a.busy, 0);
    chk("held_result_sel", bus_a.result_sel, 1);
    chk("held_run_cycles", bus_a.run_cycles, 33);

    // Run 2a/2b: start held high; restart only from IDLE after done
    c = w + 10;
    wait_cyc(c);
    bus_a.start = 1'b1;
    push_run(0, c, 2, 20, w);
    wait_cyc(w + 5); bus_a.cal_done = 1'b1; bus_a.cal_sign = 1'b0;
    push_done(0, w + 6, 0, 33, 0);
    wait_cyc(w + 6); bus_a.cal_done = 1'b0;
    c2 = w + 7;
    push_run(0, c2, 2, 20, w2);
    wait_cyc(c2 + 1); bus_a.start = 1'b0;
    wait_cyc(w2); bus_a.cal_done = 1'b1; bus_a.cal_sign = 1'b1;
    push_done(0, w2 + 1, 1, 28, 0);
    wait_cyc(w2 + 1); bus_a.cal_done = 1'b0; bus_a.cal_sign = 1'b0;
    c = w2 + 4;

`ifdef IDDMM_CTRL_TIMEOUT_EN
    // Watchdog: no cal_done, done 9 cycles after WAIT entry with error
    wait_cyc(c);
    bus_a.start = 1'b1;
    push_run(0, c, 2, 20, w);
    wait_cyc(c + 1); bus_a.start = 1'b0;
    push_done(0, w + 9, 0, 36, 1);
    wait_cyc(w + 11);
    chk("error_sticky", bus_a.error, 1);
    chk("timeout_busy", bus_a.busy, 0);
    c = w + 13;
`else
    chk("error_tied", bus_a.error, 0);
`endif

    // Reset mid-run at i=2, j=3; rst beats start; late cal_done ignored
    wait_cyc(c);
    bus_a.start = 1'b1;
    push_run(0, c, 2, 14, w);
    wait_cyc(c + 1); bus_a.start = 1'b0;
    wait_cyc(c + 18); rst = 1'b1;
    wait_cyc(c + 19);
    chk_reset_a("midrun_reset");
    bus_a.start = 1'b1;
    wait_cyc(c + 20);
    chk("rst_wins_busy", bus_a.busy, 0);
    chk("rst_wins_loop_en", bus_a.loop_en, 0);
    rst = 1'b0; bus_a.start = 1'b0;
    wait_cyc(c + 22); bus_a.cal_done = 1'b1; bus_a.cal_sign = 1'b1;
    wait_cyc(c + 23); bus_a.cal_done = 1'b0; bus_a.cal_sign = 1'b0;
    wait_cyc(c + 30);
    chk("late_cal_done_busy", bus_a.busy, 0);
    chk("late_cal_done_result_sel", bus_a.result_sel, 0);

    // GAP=0: continuous 20-cycle burst, cal_done on first WAIT cycle
    c = c + 32;
    wait_cyc(c);
    bus_b.start = 1'b1;
    push_run(1, c, 0, 20, w);
    wait_cyc(c + 1); bus_b.start = 1'b0;
    wait_cyc(w); bus_b.cal_done = 1'b1; bus_b.cal_sign = 1'b0;
    push_done(1, w + 1, 0, 22, 0);
    wait_cyc(w + 1); bus_b.cal_done = 1'b0;
    wait_cyc(w + 4);

    chk("loop_queue_empty_a", lq[0].size(), 0);
    chk("done_queue_empty_a", dq[0].size(), 0);
    chk("loop_queue_empty_b", lq[1].size(), 0);
    chk("done_queue_empty_b", dq[1].size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation time %0t exceeded bound", $time);
    $fatal(1);
  end

endmodule
